// File: rtl/mem_pkg.sv
// Shared encodings for the unified memory responder: RV32I funct3 codes,
// FSM state encoding, port ids and the access-size decode.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Size comes from funct3[1:0]; the undefined codes fall through to a word.
  function automatic size_e size_of(input logic [2:0] funct3);
    size_e sz;
    case (funct3[1:0])
      F3_SB[1:0]: sz = SZ_B;
      F3_SH[1:0]: sz = SZ_H;
      default:    sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and shifted data,
// load extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  size_e       size;
  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign size   = size_of(funct3_i);
  assign shamt  = {addr_lo_i, 3'b000};
  assign rshift = rword_i >> shamt;

  // NOTE: every output gets a default before the case statements, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    be_o         = '0;
    misaligned_o = 1'b0;
    wword_o      = wdata_i << shamt;
    rdata_o      = rword_i;

    case (size)
      SZ_B: be_o = 4'b0001 << addr_lo_i;
      SZ_H: begin
        misaligned_o = addr_lo_i[0];
        be_o         = 4'b0011 << addr_lo_i;
      end
      default: begin
        misaligned_o = |addr_lo_i;
        be_o         = 4'b1111;
      end
    endcase

    case (funct3_i)
      F3_LB:   rdata_o = {{24{rshift[7]}}, rshift[7:0]};
      F3_LH:   rdata_o = {{16{rshift[15]}}, rshift[15:0]};
      F3_LBU:  rdata_o = {24'h0, rshift[7:0]};
      F3_LHU:  rdata_o = {16'h0, rshift[15:0]};
      default: rdata_o = rword_i;
    endcase

    // A misaligned access touches nothing and returns zero.
    if (misaligned_o) begin
      be_o    = '0;
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/unified_mem_responder.sv
// Single-ported byte-addressable RAM shared by the RV32I fetch and data
// initiators; data port wins arbitration, response after LATENCY cycles.
module unified_mem_responder
  import mem_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_misaligned
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  // NOTE: RAM contents start zero-filled and are deliberately never touched
  // by reset; only stores change them.
  logic [31:0] mem [WORDS] = '{default: '0};

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;

  logic              if_rsp_q, d_rsp_q, mis_q;
  logic [31:0]       if_rdata_q, d_rdata_q;

  logic              idle, accept, go_resp;
  logic              acc_port, acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata, rword, wword, ldata, wmask;
  logic [2:0]        acc_funct3;
  logic [3:0]        be;
  logic              lane_mis, ram_we;
  logic              unused_addr_hi;

  assign idle         = (state_q == IDLE);
  assign d_req_ready  = idle & d_req_valid;
  assign if_req_ready = idle & if_req_valid & ~d_req_valid;
  assign accept       = d_req_ready | if_req_ready;

  // In IDLE the live request feeds the datapath so LATENCY = 1 can act on
  // the accept edge; afterwards the captured copy is used.
  assign acc_port   = idle ? (d_req_valid ? PORT_D : PORT_IF) : port_q;
  assign acc_addr   = idle ? (d_req_valid ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0]) : addr_q;
  assign acc_we     = idle ? (d_req_valid & d_we) : we_q;
  assign acc_wdata  = idle ? d_wdata : wdata_q;
  assign acc_funct3 = idle ? d_funct3 : funct3_q;

  assign unused_addr_hi = ^{d_addr[31:ADDR_W], if_addr[31:ADDR_W]};

  assign rword = mem[acc_addr[ADDR_W-1:2]];

  mem_lane_align u_align (
    .funct3_i     (acc_funct3),
    .addr_lo_i    (acc_addr[1:0]),
    .wdata_i      (acc_wdata),
    .rword_i      (rword),
    .be_o         (be),
    .wword_o      (wword),
    .rdata_o      (ldata),
    .misaligned_o (lane_mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = 2'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 2'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign go_resp = (state_d == RESP);
  assign ram_we  = go_resp & (acc_port == PORT_D) & acc_we & ~lane_mis;
  assign wmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  // NOTE: all clocked state uses non-blocking assignments so every process
  // sees pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      if_rsp_q   <= 1'b0;
      d_rsp_q    <= 1'b0;
      mis_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_rsp_q   <= go_resp & (acc_port == PORT_IF);
      d_rsp_q    <= go_resp & (acc_port == PORT_D);
      mis_q      <= go_resp & (acc_port == PORT_D) & lane_mis;
      if_rdata_q <= (go_resp & (acc_port == PORT_IF)) ? rword : '0;
      d_rdata_q  <= (go_resp & (acc_port == PORT_D) & ~acc_we) ? ldata : '0;
    end
  end

  // Request capture only matters on the accept edge; no reset needed.
  always_ff @(posedge clk) begin
    if (idle) begin
      port_q   <= acc_port;
      addr_q   <= acc_addr;
      we_q     <= acc_we;
      wdata_q  <= acc_wdata;
      funct3_q <= acc_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ram_we) mem[acc_addr[ADDR_W-1:2]] <= (rword & ~wmask) | (wword & wmask);
  end

  assign if_rsp_valid = if_rsp_q;
  assign if_rdata     = if_rdata_q;
  assign d_rsp_valid  = d_rsp_q;
  assign d_rdata      = d_rdata_q;
  assign d_misaligned = mis_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Bench for unified_mem_responder: one instance at LATENCY=1, one at
// LATENCY=3, checked against a byte-array memory model.
module tb_unified_mem_responder;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid [2];
  logic        if_req_ready [2];
  logic [31:0] if_addr      [2];
  logic        if_rsp_valid [2];
  logic [31:0] if_rdata     [2];
  logic        d_req_valid  [2];
  logic        d_req_ready  [2];
  logic        d_we         [2];
  logic [31:0] d_addr       [2];
  logic [31:0] d_wdata      [2];
  logic [2:0]  d_funct3     [2];
  logic        d_rsp_valid  [2];
  logic [31:0] d_rdata      [2];
  logic        d_misaligned [2];

  logic [7:0]  mm [2][4096];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unified_mem_responder #(.ADDR_W(12), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid[0]), .if_req_ready(if_req_ready[0]), .if_addr(if_addr[0]),
    .if_rsp_valid(if_rsp_valid[0]), .if_rdata(if_rdata[0]),
    .d_req_valid(d_req_valid[0]), .d_req_ready(d_req_ready[0]), .d_we(d_we[0]),
    .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_funct3(d_funct3[0]),
    .d_rsp_valid(d_rsp_valid[0]), .d_rdata(d_rdata[0]), .d_misaligned(d_misaligned[0])
  );

  unified_mem_responder #(.ADDR_W(12), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid[1]), .if_req_ready(if_req_ready[1]), .if_addr(if_addr[1]),
    .if_rsp_valid(if_rsp_valid[1]), .if_rdata(if_rdata[1]),
    .d_req_valid(d_req_valid[1]), .d_req_ready(d_req_ready[1]), .d_we(d_we[1]),
    .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_funct3(d_funct3[1]),
    .d_rsp_valid(d_rsp_valid[1]), .d_rdata(d_rdata[1]), .d_misaligned(d_misaligned[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input int k, input logic [11:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[k][a + 12'(i)]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic xact(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      output logic [31:0] rd, output logic mis);
    int lat, waitc, n;
    logic [11:0] a;
    logic [31:0] exp_rd;
    logic exp_mis;
    lat     = (k == 0) ? 1 : 3;
    a       = addr[11:0];
    n       = nbytes(f3);
    exp_mis = is_d && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
    exp_rd  = '0;
    rd      = '0;
    mis     = 1'b0;
    @(negedge clk);
    if (is_d) begin
      d_req_valid[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata; d_funct3[k] = f3;
    end else begin
      if_req_valid[k] = 1'b1; if_addr[k] = addr;
    end
    #1;
    waitc = 0;
    while (!(is_d ? d_req_ready[k] : if_req_ready[k]) && waitc < 10) begin
      @(negedge clk); #1; waitc++;
    end
    check("accept", 32'(waitc < 10), 32'd1);
    if (!is_d) exp_rd = model_load(k, {a[11:2], 2'b00}, LW);
    else if (!we && !exp_mis) exp_rd = model_load(k, a, f3);
    else if (we && !exp_mis) for (int i = 0; i < n; i++) mm[k][a + 12'(i)] = wdata[8*i +: 8];
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (j == 1) begin d_req_valid[k] = 1'b0; if_req_valid[k] = 1'b0; end
      #1;
      if (j < lat) begin
        check("early_rsp", {30'd0, if_rsp_valid[k], d_rsp_valid[k]}, 32'd0);
        check("rdata_between", if_rdata[k] | d_rdata[k], 32'd0);
      end else begin
        check("rsp_pulse", {30'd0, if_rsp_valid[k], d_rsp_valid[k]}, is_d ? 32'd1 : 32'd2);
        rd  = is_d ? d_rdata[k] : if_rdata[k];
        mis = d_misaligned[k];
        check(is_d ? "d_rdata" : "if_rdata", rd, exp_rd);
        check("misaligned", {31'd0, mis}, {31'd0, exp_mis});
        check("other_rdata", is_d ? if_rdata[k] : d_rdata[k], 32'd0);
      end
    end
    @(negedge clk); #1;
    check("rsp_drop", {30'd0, if_rsp_valid[k], d_rsp_valid[k], d_misaligned[k]} & 32'h7, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        mis;
    logic [31:0] addr;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4096; i++) mm[k][i] = 8'h00;
      if_req_valid[k] = 1'b0; if_addr[k] = '0;
      d_req_valid[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; d_funct3[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_rsp", {30'd0, if_rsp_valid[k], d_rsp_valid[k]}, 32'd0);
      check("reset_mis", {31'd0, d_misaligned[k]}, 32'd0);
      check("reset_rdata", if_rdata[k] | d_rdata[k], 32'd0);
    end
    rst = 1'b0;

    // Store/load round trip and extension at LATENCY = 1.
    xact(0, 1, 1, 32'h100, 32'hDEAD_BEEF, LW, rd, mis);
    check("t1_sw_mis", {31'd0, mis}, 32'd0);
    xact(0, 1, 0, 32'h100, 32'h0, LW, rd, mis);
    check("t1_lw", rd, 32'hDEAD_BEEF);
    xact(0, 1, 0, 32'h103, 32'h0, LB, rd, mis);
    check("t2_lb", rd, 32'hFFFF_FFDE);
    xact(0, 1, 0, 32'h103, 32'h0, LBU, rd, mis);
    check("t2_lbu", rd, 32'h0000_00DE);
    xact(0, 1, 0, 32'h102, 32'h0, LH, rd, mis);
    check("t2_lh", rd, 32'hFFFF_DEAD);
    xact(0, 1, 0, 32'h100, 32'h0, LHU, rd, mis);
    check("t2_lhu", rd, 32'h0000_BEEF);
    xact(0, 1, 1, 32'h101, 32'h5A, 3'b000, rd, mis);
    xact(0, 1, 0, 32'h100, 32'h0, LW, rd, mis);
    check("t3_lw_after_sb", rd, 32'hDEAD_5AEF);
    xact(0, 1, 1, 32'h101, 32'h1234, 3'b001, rd, mis);
    check("t3_sh_mis", {31'd0, mis}, 32'd1);
    xact(0, 1, 0, 32'h100, 32'h0, LW, rd, mis);
    check("t3_lw_unchanged", rd, 32'hDEAD_5AEF);

    // Fetch wraps modulo 4 KiB and ignores the low address bits.
    xact(0, 1, 1, 32'h000, 32'hCAFE_F00D, LW, rd, mis);
    xact(0, 0, 0, 32'h1002, 32'h0, LW, rd, mis);
    check("t5_fetch_wrap", rd, 32'hCAFE_F00D);

    // Simultaneous requests at LATENCY = 3: data first, fetch right after.
    xact(1, 1, 1, 32'h040, 32'h0BAD_C0DE, LW, rd, mis);
    xact(1, 1, 1, 32'h044, 32'h1234_5678, LW, rd, mis);
    @(negedge clk);
    d_req_valid[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h040; d_funct3[1] = LW;
    if_req_valid[1] = 1'b1; if_addr[1] = 32'h044;
    #1;
    check("t4_d_ready", {31'd0, d_req_ready[1]}, 32'd1);
    check("t4_if_ready", {31'd0, if_req_ready[1]}, 32'd0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 1) d_req_valid[1] = 1'b0;
      #1;
      check("t4_d_rsp", {31'd0, d_rsp_valid[1]}, 32'(j == 3));
      check("t4_if_rsp_quiet", {31'd0, if_rsp_valid[1]}, 32'd0);
      check("t4_if_held", {31'd0, if_req_ready[1]}, 32'd0);
      if (j == 3) check("t4_d_rdata", d_rdata[1], 32'h0BAD_C0DE);
    end
    @(negedge clk); #1;
    check("t4_if_accept", {31'd0, if_req_ready[1]}, 32'd1);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 1) if_req_valid[1] = 1'b0;
      #1;
      check("t4_if_rsp", {31'd0, if_rsp_valid[1]}, 32'(j == 3));
      if (j == 3) check("t4_if_rdata", if_rdata[1], 32'h1234_5678);
    end

    // Reset during BUSY aborts the pending store.
    @(negedge clk); @(negedge clk);
    d_req_valid[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h200; d_wdata[1] = 32'h1111_1111; d_funct3[1] = LW;
    #1;
    check("t6_accept", {31'd0, d_req_ready[1]}, 32'd1);
    @(negedge clk);
    d_req_valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_out_rsp", {30'd0, if_rsp_valid[1], d_rsp_valid[1]}, 32'd0);
    check("t6_out_rdata", if_rdata[1] | d_rdata[1], 32'd0);
    check("t6_out_mis", {31'd0, d_misaligned[1]}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      check("t6_no_rsp", {31'd0, d_rsp_valid[1]}, 32'd0);
    end
    xact(1, 1, 0, 32'h200, 32'h0, LW, rd, mis);
    check("t6_lw_old", rd, 32'h0);

    // Randomised mix of fetches, loads and stores on both latencies.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 150; t++) begin
        addr = $urandom() & 32'hFFFF_F03F;
        xact(k, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, addr, $urandom(),
             3'($urandom_range(0, 7)), rd, mis);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
